// File: rtl/id_forward_scoreboard.sv
// ID-stage forwarding and hazard unit.
// Tracks in-flight destination registers in a small shift-register scoreboard
// (entry 1 = EX, higher entries are older stages). From it, each ID source
// operand gets a forward select, and load-use or too-early operands raise a stall.
module id_forward_scoreboard #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned FWD_MIN    = 2,
    parameter int unsigned LOAD_READY = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       id_valid,
    input  logic                                       id_reg_write,
    input  logic                                       id_is_load,
    input  logic [REG_AW-1:0]                          id_rd,
    input  logic [NUM_SRC*REG_AW-1:0]                  id_src,
    input  logic [NUM_SRC-1:0]                         id_src_used,
    input  logic                                       flush,
    input  logic                                       hold,
    output logic [NUM_SRC*$clog2(PIPE_DEPTH+1)-1:0]    fwd_sel,
    output logic                                       stall,
    output logic [CNT_W-1:0]                           stall_count
);

    localparam int unsigned SW = $clog2(PIPE_DEPTH + 1);

    // Entry indices are 1-based so an entry index is directly its forward select.
    logic [PIPE_DEPTH:1] v_q, v_d;
    logic [PIPE_DEPTH:1] ld_q, ld_d;
    logic [REG_AW-1:0]   rd_q [1:PIPE_DEPTH];
    logic [REG_AW-1:0]   rd_d [1:PIPE_DEPTH];
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_SRC-1:0][SW-1:0] win;
    logic [NUM_SRC-1:0]         win_ld;
    logic [NUM_SRC-1:0]         op_stall;

    // Find the youngest matching entry per operand and decide forward or stall.
    always_comb begin
        win      = '0;
        win_ld   = '0;
        op_stall = '0;
        fwd_sel  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            // Scan oldest to youngest so the youngest match overwrites older ones.
            for (int unsigned k = PIPE_DEPTH; k >= 1; k--) begin
                if (id_valid && id_src_used[i] &&
                    (id_src[i*REG_AW +: REG_AW] != '0) &&
                    v_q[k] && (rd_q[k] == id_src[i*REG_AW +: REG_AW])) begin
                    win[i]    = SW'(k);
                    win_ld[i] = ld_q[k];
                end
            end
            if (win[i] != '0) begin
                if ((32'(win[i]) < FWD_MIN) || (win_ld[i] && (32'(win[i]) < LOAD_READY))) begin
                    op_stall[i] = 1'b1;
                end else begin
                    fwd_sel[i*SW +: SW] = win[i];
                end
            end
        end
        // A redirect or a frozen pipeline makes the stall meaningless.
        stall = (|op_stall) && !hold && !flush;
    end

    // Advance the scoreboard and the saturating stall counter.
    always_comb begin
        v_d   = v_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (!hold) begin
            for (int unsigned k = PIPE_DEPTH; k >= 2; k--) begin
                v_d[k]  = v_q[k-1];
                ld_d[k] = ld_q[k-1];
                rd_d[k] = rd_q[k-1];
            end
            // Register 0 is never tracked; stalled or flushed slots become bubbles.
            v_d[1]  = id_valid && id_reg_write && (id_rd != '0) && !stall && !flush;
            ld_d[1] = id_is_load;
            rd_d[1] = id_rd;
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; rd/ld are qualified by v.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
        ld_q <= ld_d;
        rd_q <= rd_d;
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_forward_scoreboard.sv
// Bench for id_forward_scoreboard: a hand-derived vector table, a saturation
// sequence on a narrow-counter instance, then random stimulus against an
// age-based producer-list reference model.
module tb_id_forward_scoreboard;

    localparam int unsigned REG_AW     = 5;
    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned PIPE_DEPTH = 3;
    localparam int unsigned FWD_MIN    = 2;
    localparam int unsigned LOAD_READY = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_reg_write, id_is_load;
    logic [4:0]  id_rd;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic        flush, hold;
    logic [3:0]  fwd_sel, fwd_sel_n;
    logic        stall, stall_n;
    logic [15:0] stall_count;
    logic [3:0]  stall_count_n;

    id_forward_scoreboard u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_rd(id_rd), .id_src(id_src), .id_src_used(id_src_used),
        .flush(flush), .hold(hold), .fwd_sel(fwd_sel), .stall(stall),
        .stall_count(stall_count)
    );

    id_forward_scoreboard #(.CNT_W(4)) u_dut_narrow (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_rd(id_rd), .id_src(id_src), .id_src_used(id_src_used),
        .flush(flush), .hold(hold), .fwd_sel(fwd_sel_n), .stall(stall_n),
        .stall_count(stall_count_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst, v, rw, ld;
        bit [4:0] rd, s0, s1;
        bit [1:0] used;
        bit       fl, hd;
        int       e0, e1, est, ecnt;
    } vec_t;

    typedef struct {
        int       age;
        bit [4:0] rd;
        bit       ld;
    } prod_t;

    vec_t  tbl[$];
    prod_t prods[$];
    int    mcnt = 0;
    int    nvec = 0;
    int    nerr = 0;

    function automatic void row(bit rst, bit v, bit rw, bit ld, bit [4:0] rd, bit [4:0] s0,
                                bit [4:0] s1, bit [1:0] used, bit fl, bit hd,
                                int e0, int e1, int est, int ecnt);
        vec_t r;
        r = '{rst, v, rw, ld, rd, s0, s1, used, fl, hd, e0, e1, est, ecnt};
        tbl.push_back(r);
    endfunction

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    task automatic drive(input vec_t r);
        reset        = r.rst;
        id_valid     = r.v;
        id_reg_write = r.rw;
        id_is_load   = r.ld;
        id_rd        = r.rd;
        id_src       = {r.s1, r.s0};
        id_src_used  = r.used;
        flush        = r.fl;
        hold         = r.hd;
    endtask

    // Reference: the youngest in-flight producer of a register decides the operand.
    function automatic void model_eval(output int sel0, output int sel1, output bit mstall);
        int  sel[2];
        bit  st;
        st = 0;
        for (int i = 0; i < 2; i++) begin
            bit [4:0] src;
            int       best;
            bit       bld;
            src  = (i == 0) ? id_src[4:0] : id_src[9:5];
            best = 0;
            bld  = 0;
            sel[i] = 0;
            if (id_valid && id_src_used[i] && src != 0) begin
                foreach (prods[j]) begin
                    if (prods[j].rd == src && (best == 0 || prods[j].age < best)) begin
                        best = prods[j].age;
                        bld  = prods[j].ld;
                    end
                end
            end
            if (best != 0) begin
                if (best < int'(FWD_MIN) || (bld && best < int'(LOAD_READY))) st = 1;
                else sel[i] = best;
            end
        end
        sel0   = sel[0];
        sel1   = sel[1];
        mstall = st && !hold && !flush;
    endfunction

    function automatic void model_update(bit mstall);
        prod_t p;
        if (!reset) begin
            prods.delete();
            mcnt = 0;
        end else if (!hold) begin
            foreach (prods[j]) prods[j].age++;
            for (int j = prods.size() - 1; j >= 0; j--) begin
                if (prods[j].age > int'(PIPE_DEPTH)) prods.delete(j);
            end
            if (!mstall && !flush && id_valid && id_reg_write && id_rd != 0) begin
                p = '{1, id_rd, id_is_load};
                prods.push_back(p);
            end
            if (mstall) mcnt++;
        end
    endfunction

    task automatic cycle(input bit has_exp, input vec_t e, input int idx);
        int s0, s1;
        bit ms;
        @(negedge clk);
        model_eval(s0, s1, ms);
        check("model_sel0", 32'(fwd_sel[1:0]), s0);
        check("model_sel1", 32'(fwd_sel[3:2]), s1);
        check("model_stall", 32'(stall), 32'(ms));
        check("model_cnt", 32'(stall_count), (mcnt > 65535) ? 65535 : mcnt);
        check("model_cnt_narrow", 32'(stall_count_n), (mcnt > 15) ? 15 : mcnt);
        check("narrow_stall", 32'(stall_n), 32'(ms));
        if (has_exp) begin
            check($sformatf("tbl%0d_sel0", idx), 32'(fwd_sel[1:0]), e.e0);
            check($sformatf("tbl%0d_sel1", idx), 32'(fwd_sel[3:2]), e.e1);
            check($sformatf("tbl%0d_stall", idx), 32'(stall), e.est);
            check($sformatf("tbl%0d_cnt", idx), 32'(stall_count), e.ecnt);
        end
        @(posedge clk);
        model_update(ms);
        #1;
    endtask

    initial begin
        vec_t r;
        // rst v rw ld rd s0 s1 used fl hd | sel0 sel1 stall cnt
        row(0, 1, 1, 1,  7,  7,  7, 3, 0, 0, 0, 0, 0, 0);  // reset with busy inputs
        row(0, 1, 1, 1,  7,  7,  7, 3, 0, 0, 0, 0, 0, 0);
        row(1, 1, 0, 0,  0,  3,  4, 3, 0, 0, 0, 0, 0, 0);  // no producers
        row(1, 1, 1, 0,  8,  1,  2, 3, 0, 0, 0, 0, 0, 0);  // add $8
        row(1, 1, 1, 0, 10,  8,  0, 1, 0, 0, 0, 0, 1, 0);  // use $8 at EX: stall
        row(1, 1, 1, 0, 10,  8,  0, 1, 0, 0, 2, 0, 0, 1);  // forward from 2
        row(1, 1, 0, 0,  0,  8,  0, 1, 0, 0, 3, 0, 0, 1);  // forward from 3
        row(1, 1, 1, 1,  9,  0,  0, 0, 0, 0, 0, 0, 0, 1);  // lw $9
        row(1, 1, 0, 0,  0,  0,  9, 2, 0, 0, 0, 0, 1, 1);  // load-use stall x2
        row(1, 1, 0, 0,  0,  0,  9, 2, 0, 0, 0, 0, 1, 2);
        row(1, 1, 0, 0,  0,  0,  9, 2, 0, 0, 0, 3, 0, 3);
        row(1, 1, 1, 0,  5,  0,  0, 0, 0, 0, 0, 0, 0, 3);  // add $5
        row(1, 1, 1, 0,  5,  0,  0, 0, 0, 0, 0, 0, 0, 3);  // sub $5
        row(1, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 3);
        row(1, 1, 0, 0,  0,  5,  0, 1, 0, 0, 2, 0, 0, 3);  // youngest wins
        row(1, 1, 1, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 3);  // $0 writer
        row(1, 1, 0, 0,  0,  0,  0, 3, 0, 0, 0, 0, 0, 3);  // $0 reader
        row(1, 1, 1, 0, 12,  0,  0, 0, 0, 0, 0, 0, 0, 3);  // add $12
        row(1, 1, 1, 0, 13, 12,  0, 1, 1, 0, 0, 0, 0, 3);  // flush masks hazard
        row(1, 1, 0, 0,  0, 12, 13, 3, 0, 0, 2, 0, 0, 3);  // $13 was not captured
        row(1, 1, 1, 1, 14,  0,  0, 0, 0, 0, 0, 0, 0, 3);  // lw $14
        row(1, 1, 0, 0,  0, 14,  0, 1, 0, 0, 0, 0, 1, 3);
        row(1, 1, 0, 0,  0, 14,  0, 1, 0, 1, 0, 0, 0, 4);  // hold x3 freezes
        row(1, 1, 0, 0,  0, 14,  0, 1, 0, 1, 0, 0, 0, 4);
        row(1, 1, 0, 0,  0, 14,  0, 1, 0, 1, 0, 0, 0, 4);
        row(1, 1, 0, 0,  0, 14,  0, 1, 0, 0, 0, 0, 1, 4);  // stall resumes
        row(1, 1, 0, 0,  0, 14,  0, 1, 0, 0, 3, 0, 0, 5);
        row(1, 1, 1, 0, 20,  0,  0, 0, 0, 0, 0, 0, 0, 5);  // add $20
        row(1, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 5);
        row(1, 1, 0, 0,  0,  3, 20, 1, 0, 0, 0, 0, 0, 5);  // src1 unused
        row(1, 1, 0, 0,  0,  3, 20, 3, 0, 0, 0, 3, 0, 5);
        row(1, 1, 1, 0, 21,  0,  0, 0, 0, 0, 0, 0, 0, 5);  // add $21
        row(1, 1, 0, 0,  0, 21, 21, 3, 0, 0, 0, 0, 1, 5);  // both hazard: one stall
        row(1, 1, 0, 0,  0, 21, 21, 3, 0, 0, 2, 2, 0, 6);

        r = tbl[0];
        drive(r);
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            cycle(1, tbl[i], i);
        end

        // Saturation: alternate producer/consumer of $1 for 20 stall cycles.
        r = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(r);
        cycle(0, r, 0);
        r = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 40; i++) begin
            drive(r);
            cycle(0, r, 0);
        end
        @(negedge clk);
        check("sat_narrow", 32'(stall_count_n), 15);
        check("sat_wide", 32'(stall_count), 20);
        @(posedge clk);
        #1;

        for (int n = 0; n < 2000; n++) begin
            r.rst  = ($urandom_range(63) != 0);
            r.v    = ($urandom_range(7) != 0);
            r.rw   = $urandom_range(1);
            r.ld   = ($urandom_range(2) == 0);
            r.rd   = 5'($urandom_range(7));
            r.s0   = 5'($urandom_range(7));
            r.s1   = 5'($urandom_range(7));
            r.used = 2'($urandom_range(3));
            r.fl   = ($urandom_range(7) == 0);
            r.hd   = ($urandom_range(7) == 0);
            drive(r);
            cycle(0, r, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/id_forward_scoreboard.md
Name: id_forward_scoreboard

Overview:
- Parametrised ID-stage forwarding and hazard unit for the pipelined core.
- Keeps its own shift-register scoreboard of in-flight destination registers, one entry per post-ID stage, instead of taking EX/MEM and MEM/WB register fields as inputs.
- Each cycle it produces per-source-operand forward selects and a load-use/early-operand stall, and it keeps a saturating stall counter.
- Sits beside the ID stage and drives the ID operand muxes and the IF/ID hold.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands checked per ID instruction.
- PIPE_DEPTH, 3, tracked stages after ID (entry 1 = EX, 2 = EX/MEM, 3 = MEM/WB).
- FWD_MIN, 2, lowest entry index whose ALU result can be forwarded into ID.
- LOAD_READY, 3, lowest entry index whose load result can be forwarded into ID.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_reg_write  in  1  ID instruction writes a register.
- id_is_load  in  1  ID instruction is a load.
- id_rd  in  REG_AW  ID destination register.
- id_src  in  NUM_SRC*REG_AW  source register addresses; operand i is at bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  per-operand "operand is actually read" mask.
- flush  in  1  kill the ID instruction (branch/jump redirect); it must not enter entry 1.
- hold  in  1  global pipeline freeze (e.g. memory wait).
- fwd_sel  out  NUM_SRC*SW  per-operand select; SW = clog2(PIPE_DEPTH+1). 0 = register file, k = entry k.
- stall  out  1  hold PC and IF/ID, insert bubble into EX.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- State: PIPE_DEPTH entries, each {v, rd, ld}.
- Reset (reset==0 at clk edge): all v = 0, stall_count = 0. With all entries invalid, fwd_sel = 0 and stall = 0.
- Match rule: operand i matches entry k when all of the following hold:
  - id_valid and id_src_used[i];
  - id_src[i] != 0;
  - entry k has v = 1;
  - entry k rd == id_src[i].
- Priority: the youngest entry (smallest k) wins. Older matches are ignored.
- For the winning entry k of operand i:
  - If k < FWD_MIN, or ld = 1 and k < LOAD_READY: operand i raises stall, and fwd_sel[i] = 0.
  - Otherwise fwd_sel[i] = k.
  - No match: fwd_sel[i] = 0.
- stall = OR over all operands, masked to 0 when hold = 1 or flush = 1.
- fwd_sel and stall are combinational from the entries and the ID inputs, with zero latency.
- Entry update on each clk edge with reset = 1:
  - hold = 1: all entries unchanged, counter unchanged.
  - Otherwise entries k >= 2 take entry k-1 and entry PIPE_DEPTH drops out.
  - Entry 1 gets a bubble (v = 0) if stall or flush is 1.
  - Else entry 1 gets v = id_valid & id_reg_write & (id_rd != 0), with rd = id_rd and ld = id_is_load.
- Counter: stall_count increments when stall = 1 and hold = 0, and saturates at all-ones (no wrap).
- Register 0 is never tracked and never matched.
- Simultaneous flush and hazard: flush wins, so there is no stall and a bubble enters entry 1.
- Multiple operands hazarding at once: a single stall.
- Multi-cycle hazards: stall repeats each cycle until the producer reaches a forwardable entry.
- Reset asserted mid-operation: scoreboard cleared on that edge. Instructions already in flight lose tracking; the core flushes on reset.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with random inputs -> fwd_sel = 0, stall = 0, stall_count = 0. After release, with no producers, every operand gets fwd_sel = 0.
- ALU chain: issue add $8, then next cycle an instruction with src0 = $8 -> stall = 1 for 1 cycle. Next cycle fwd_sel[0] = 2, then fwd_sel[0] = 3 if issued one cycle later. stall_count = 1.
- Load-use: lw $9, then next cycle src1 = $9 -> stall = 1 for 2 cycles, then fwd_sel[1] = 3. stall_count = 2.
- Priority and $0: add $5 then sub $5, then a consumer of $5 issued two cycles after sub -> fwd_sel = 2 (sub), not 3. A consumer of $0 with a $0 writer in flight -> fwd_sel = 0, stall = 0.
- Flush/hold/mask:
  - flush = 1 alongside a hazard -> stall = 0, and entry 1 does not capture id_rd.
  - hold = 1 for 3 cycles during a load-use stall -> stall = 0, entries frozen, counter frozen; the stall resumes after release.
  - id_src_used[1] = 0 with a matching src1 -> fwd_sel[1] = 0, no stall.
- Saturation: CNT_W = 4 build, force 20 stall cycles -> stall_count sticks at 15.
